// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with a start/done handshake.
//   Single-cycle ops (logic, shift, rotate, add, sub, neg, not) finish one
//   cycle after accept. mul is a radix-2 Booth iteration. div is a restoring
//   divide on magnitudes followed by a sign fix-up.
//   Optional divider: define SEQ_ALU_DIV_EN to build it. When it is undefined,
//   opcode 10000 acts as an unknown opcode and div_by_zero is tied low.
// Ports:
//   clk         system clock, rising edge
//   clr         asynchronous active-low reset
//   start       request, sampled while busy = 0
//   opcode[4:0] operation select, latched at accept
//   y, b        operands, latched at accept
//   busy        iterative op in progress
//   done        one-cycle pulse when z is updated
//   z[2W-1:0]   result, held until the next done
//   div_by_zero set with done on a divide by zero
//
// state | meaning
// IDLE  | accepting; single-cycle results retire from here
// MUL   | Booth iterations, then result write
// DIV   | restoring iterations on magnitudes
// FIX   | apply quotient/remainder signs, write result
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [4:0]         opcode,
    input  logic [WIDTH-1:0]   y,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] z,
    output logic               div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [4:0] OP_LOAD  = 5'b00000, OP_LOADI = 5'b00001,
                           OP_STORE = 5'b00010, OP_ADD   = 5'b00011,
                           OP_SUB   = 5'b00100, OP_AND   = 5'b00101,
                           OP_OR    = 5'b00110, OP_SHR   = 5'b00111,
                           OP_SHRA  = 5'b01000, OP_SHL   = 5'b01001,
                           OP_ROR   = 5'b01010, OP_ROL   = 5'b01011,
                           OP_ADDI  = 5'b01100, OP_ANDI  = 5'b01101,
                           OP_ORI   = 5'b01110, OP_MUL   = 5'b01111,
                           OP_DIV   = 5'b10000, OP_NEG   = 5'b10001,
                           OP_NOT   = 5'b10010;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [4:0]           op_q, op_d;
    logic [WIDTH-1:0]     y_q, y_d, b_q, b_d;
    logic                 pend_q, pend_d;
    logic [WIDTH:0]       acc_q, acc_d;
    logic [WIDTH-1:0]     qr_q, qr_d;
    logic                 q1_q, q1_d;
    logic [2*WIDTH-1:0]   z_q, z_d;
    logic                 done_q, done_d;

    logic accept;
    assign accept = start && (state_q == S_IDLE);

    // Single-cycle datapath, evaluated on the latched operands.
    logic [SHW-1:0]     sh;
    logic [2*WIDTH-1:0] yy, rr, rl;
    logic [WIDTH-1:0]   sc_lo, sc_hi;
    logic [WIDTH:0]     booth_sum;

    assign sh = b_q[SHW-1:0];
    assign yy = {y_q, y_q};
    assign rr = yy >> sh;
    assign rl = yy << sh;

`ifdef SEQ_ALU_DIV_EN
    logic                 sc_dbz;
    logic                 dbz_q, dbz_d;
    logic [WIDTH-1:0]     ymag, dmag;
    logic [WIDTH:0]       rs;

    assign ymag = y[WIDTH-1] ? -y : y;
    assign dmag = b_q[WIDTH-1] ? -b_q : b_q;
    assign rs   = {acc_q[WIDTH-1:0], qr_q[WIDTH-1]};
`endif

    always_comb begin
        sc_lo = '0;
        sc_hi = '0;
`ifdef SEQ_ALU_DIV_EN
        sc_dbz = 1'b0;
`endif
        case (op_q)
            OP_ADD, OP_ADDI, OP_LOAD, OP_LOADI, OP_STORE: sc_lo = y_q + b_q;
            OP_SUB:          sc_lo = y_q - b_q;
            OP_AND, OP_ANDI: sc_lo = y_q & b_q;
            OP_OR, OP_ORI:   sc_lo = y_q | b_q;
            OP_SHR:          sc_lo = y_q >> sh;
            OP_SHRA:         sc_lo = WIDTH'($signed(y_q) >>> sh);
            OP_SHL:          sc_lo = y_q << sh;
            OP_ROR:          sc_lo = rr[WIDTH-1:0];
            OP_ROL:          sc_lo = rl[2*WIDTH-1:WIDTH];
            OP_NEG:          sc_lo = -y_q;
            OP_NOT:          sc_lo = ~y_q;
`ifdef SEQ_ALU_DIV_EN
            // Only a zero divisor retires through this path.
            OP_DIV: begin
                sc_hi  = y_q;
                sc_lo  = '1;
                sc_dbz = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        booth_sum = acc_q;
        case ({qr_q[0], q1_q})
            2'b01:   booth_sum = acc_q + {b_q[WIDTH-1], b_q};
            2'b10:   booth_sum = acc_q - {b_q[WIDTH-1], b_q};
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        y_d     = y_q;
        b_d     = b_q;
        pend_d  = 1'b0;
        acc_d   = acc_q;
        qr_d    = qr_q;
        q1_d    = q1_q;
        z_d     = z_q;
        done_d  = 1'b0;

        if (pend_q) begin
            z_d    = {sc_hi, sc_lo};
            done_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d = opcode;
                    y_d  = y;
                    b_d  = b;
                    if (opcode == OP_MUL) begin
                        state_d = S_MUL;
                        cnt_d   = CW'(WIDTH);
                        acc_d   = '0;
                        qr_d    = y;
                        q1_d    = 1'b0;
                    end
`ifdef SEQ_ALU_DIV_EN
                    else if (opcode == OP_DIV && b != '0) begin
                        state_d = S_DIV;
                        cnt_d   = CW'(WIDTH);
                        acc_d   = '0;
                        qr_d    = ymag;
                    end
`endif
                    else begin
                        pend_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (cnt_q != '0) begin
                    // Arithmetic shift right of {acc, qr, q1}.
                    acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    qr_d  = {booth_sum[0], qr_q[WIDTH-1:1]};
                    q1_d  = qr_q[0];
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    z_d     = {acc_q[WIDTH-1:0], qr_q};
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
`ifdef SEQ_ALU_DIV_EN
            S_DIV: begin
                if (cnt_q != '0) begin
                    if (rs >= {1'b0, dmag}) begin
                        acc_d = rs - {1'b0, dmag};
                        qr_d  = {qr_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = rs;
                        qr_d  = {qr_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // Quotient negative when signs differ; remainder follows y.
                z_d[WIDTH-1:0]       = (y_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -qr_q : qr_q;
                z_d[2*WIDTH-1:WIDTH] = y_q[WIDTH-1] ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

`ifdef SEQ_ALU_DIV_EN
    // Iterative completions never coincide with pend_q, so they clear the flag.
    assign dbz_d = done_d ? (pend_q && sc_dbz) : dbz_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) dbz_q <= 1'b0;
        else      dbz_q <= dbz_d;
    end

    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            y_q     <= '0;
            b_q     <= '0;
            pend_q  <= 1'b0;
            acc_q   <= '0;
            qr_q    <= '0;
            q1_q    <= 1'b0;
            z_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            y_q     <= y_d;
            b_q     <= b_d;
            pend_q  <= pend_d;
            acc_q   <= acc_d;
            qr_q    <= qr_d;
            q1_q    <= q1_d;
            z_q     <= z_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign z    = z_q;
endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
    localparam int W = 32;

    localparam logic [4:0] ADD = 5'b00011, SUB = 5'b00100, AND_ = 5'b00101,
                           OR_ = 5'b00110, SHR = 5'b00111, SHRA = 5'b01000,
                           SHL = 5'b01001, ROR = 5'b01010, ROL = 5'b01011,
                           ADDI = 5'b01100, MUL = 5'b01111, DIV = 5'b10000,
                           NEG = 5'b10001, NOT_ = 5'b10010, BAD = 5'b11111;

    logic           clk, clr, start;
    logic [4:0]     opcode;
    logic [W-1:0]   y, b;
    logic           busy, done, div_by_zero;
    logic [2*W-1:0] z;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .clr(clr), .start(start), .opcode(opcode), .y(y), .b(b),
        .busy(busy), .done(done), .z(z), .div_by_zero(div_by_zero)
    );

    typedef struct {
        logic [2*W-1:0] z;
        logic           dbz;
        int             cyc;
        string          name;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every done must match the oldest outstanding expectation.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (clr && done) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: z=%h at cycle %0d, no op outstanding", z, cyc);
            end else begin
                e = sb.pop_front();
                if (z !== e.z || div_by_zero !== e.dbz || cyc != e.cyc) begin
                    fails++;
                    $display("FAIL %s: got z=%h dbz=%b cycle=%0d, expected z=%h dbz=%b cycle=%0d",
                             e.name, z, div_by_zero, cyc, e.z, e.dbz, e.cyc);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [2*W-1:0] ez, input logic edbz, input int lat, input string nm);
        exp_t e;
        e.z = ez; e.dbz = edbz; e.cyc = cyc + 1 + lat; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: %0d ops without done, first %s", sb.size(), sb[0].name);
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [4:0] op, input logic [W-1:0] ya, input logic [W-1:0] ba,
                          input logic [2*W-1:0] ez, input logic edbz, input int lat, input string nm);
        @(negedge clk);
        start = 1'b1; opcode = op; y = ya; b = ba;
        push(ez, edbz, lat, nm);
        @(negedge clk);
        start = 1'b0;
        check({nm, "_busy"}, {63'd0, busy}, (lat > 1) ? 64'd1 : 64'd0);
        wait_drain();
    endtask

    initial begin
        int n;
        clr = 1'b0; start = 1'b0; opcode = '0; y = '0; b = '0;
        #1;
        check("reset_z", z, 64'd0);
        check("reset_busy_done_dbz", {61'd0, busy, done, div_by_zero}, 64'd0);
        repeat (3) @(negedge clk);
        clr = 1'b1;

        run_op(ADD,  32'd123,        32'd7,          64'd130,                  1'b0, 1, "add");
        run_op(SUB,  32'd4,          32'd15,         64'h00000000_FFFFFFF5,    1'b0, 1, "sub");
        run_op(SHRA, 32'h80000000,   32'd4,          64'h00000000_F8000000,    1'b0, 1, "shra");
        run_op(SHR,  32'h80000000,   32'd4,          64'h00000000_08000000,    1'b0, 1, "shr");
        run_op(ROR,  32'd1,          32'd33,         64'h00000000_80000000,    1'b0, 1, "ror");
        run_op(ROL,  32'h80000001,   32'd4,          64'h00000000_00000018,    1'b0, 1, "rol");
        run_op(SHL,  32'd1,          32'd2,          64'd4,                    1'b0, 1, "shl");
        run_op(AND_, 32'hF0F0F0F0,   32'h0FF00FF0,   64'h00000000_00F000F0,    1'b0, 1, "and");
        run_op(OR_,  32'hF0F0F0F0,   32'h0FF00FF0,   64'h00000000_FFF0FFF0,    1'b0, 1, "or");
        run_op(ADDI, 32'hFFFFFFFF,   32'd1,          64'd0,                    1'b0, 1, "addi_carry");
        run_op(NEG,  32'd5,          32'd0,          64'h00000000_FFFFFFFB,    1'b0, 1, "neg");
        run_op(NEG,  32'h80000000,   32'd0,          64'h00000000_80000000,    1'b0, 1, "neg_min");
        run_op(NOT_, 32'h0000FFFF,   32'd0,          64'h00000000_FFFF0000,    1'b0, 1, "not");
        run_op(BAD,  32'd55,         32'd66,         64'd0,                    1'b0, 1, "unknown_op");

        // Back-to-back single-cycle ops on consecutive edges.
        @(negedge clk);
        start = 1'b1; opcode = ADD; y = 32'd10; b = 32'd20;
        push(64'd30, 1'b0, 1, "b2b_add0");
        @(negedge clk);
        opcode = SUB; y = 32'd10; b = 32'd3;
        push(64'd7, 1'b0, 1, "b2b_sub1");
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        // mul with a dropped start mid-op, then an add in the done cycle.
        @(negedge clk);
        start = 1'b1; opcode = MUL; y = -32'sd3; b = 32'd12;
        push(64'hFFFFFFFF_FFFFFFDC, 1'b0, 33, "mul_neg");
        @(negedge clk);
        start = 1'b0;
        check("mul_busy_start", {63'd0, busy}, 64'd1);
        repeat (3) @(negedge clk);
        start = 1'b1; opcode = ADD; y = 32'd1; b = 32'd1;
        @(negedge clk);
        start = 1'b0;
        check("mul_busy_mid", {63'd0, busy}, 64'd1);
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("mul_busy_at_done", {63'd0, busy}, 64'd0);
        start = 1'b1; opcode = ADD; y = 32'd40; b = 32'd2;
        push(64'd42, 1'b0, 1, "add_after_mul");
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        run_op(MUL, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0, 33, "mul_min_min");
        run_op(MUL, 32'd7,        32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFF9, 1'b0, 33, "mul_by_m1");

`ifdef SEQ_ALU_DIV_EN
        run_op(DIV, 32'd27,       32'd12,       64'h00000003_00000002, 1'b0, 34, "div_pos");
        run_op(DIV, -32'sd27,     32'd4,        64'hFFFFFFFD_FFFFFFFA, 1'b0, 34, "div_neg");
        run_op(DIV, 32'd7,        -32'sd2,      64'h00000001_FFFFFFFD, 1'b0, 34, "div_negdiv");
        run_op(DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 34, "div_ovf");
        run_op(DIV, 32'd9,        32'd0,        64'h00000009_FFFFFFFF, 1'b1, 1,  "div_zero");
        check("dbz_held", {63'd0, div_by_zero}, 64'd1);
        run_op(ADD, 32'd1,        32'd1,        64'd2,                 1'b0, 1,  "add_clears_dbz");
`else
        run_op(DIV, 32'd27,       32'd12,       64'd0,                 1'b0, 1,  "div_disabled");
        run_op(DIV, 32'd9,        32'd0,        64'd0,                 1'b0, 1,  "div_zero_disabled");
`endif

        // Reset mid-mul: outputs clear at once and the op never completes.
        run_op(ADD, 32'd100, 32'd1, 64'd101, 1'b0, 1, "add_before_clr");
        @(negedge clk);
        start = 1'b1; opcode = MUL; y = 32'd5; b = 32'd5;
        push(64'd25, 1'b0, 33, "mul_aborted");
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        clr = 1'b0;
        #1;
        check("clr_z", z, 64'd0);
        check("clr_busy_done", {62'd0, busy, done}, 64'd0);
        void'(sb.pop_back());
        @(negedge clk);
        clr = 1'b1;
        repeat (40) @(negedge clk);
        run_op(ADD, 32'd8, 32'd9, 64'd17, 1'b0, 1, "add_after_clr");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
